// File: rtl/perf_pkg.sv
// Shared definitions for the machine-mode performance counter unit:
// CSR addresses, mcountinhibit bit positions and the default counter width.
package perf_pkg;

    localparam int CNT_WIDTH_DEF = 64;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_HPMCOUNTER3H  = 12'hC83;

    localparam int INH_CY   = 0;
    localparam int INH_IR   = 2;
    localparam int INH_HPM3 = 3;

endpackage

// File: rtl/perf_counter.sv
// One free-running event counter with independently writable 32-bit halves.
// A write to either half suppresses the increment for the whole counter that cycle.
module perf_counter
    import perf_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 inhibit_i,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic [31:0]          wdata_i,
    output logic [CNT_WIDTH-1:0] value_o
);

    // Upper half is CNT_WIDTH-32 bits; the unit assumes 32 < CNT_WIDTH <= 64.
    localparam int HI_W = CNT_WIDTH - 32;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[31:0]           = wdata_i;
            if (wr_hi_i) cnt_d[CNT_WIDTH-1:32] = wdata_i[HI_W-1:0];
        end else if (inc_i && !inhibit_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/perf_counters.sv
// mcycle / minstret / mcountinhibit CSR unit with user read-only shadows.
// Define PERF_HPM_EN to add mhpmcounter3 (counts stall cycles, inhibit bit 3).
module perf_counters
    import perf_pkg::*;
#(
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF,
    parameter int CYCLE_OUT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       retire_valid,
    input  logic                       stall,
    input  logic                       csr_re,
    input  logic [11:0]                csr_raddr,
    output logic [31:0]                csr_rdata,
    output logic                       csr_rvalid,
    input  logic                       csr_we,
    input  logic [11:0]                csr_waddr,
    input  logic [31:0]                csr_wdata,
    output logic                       csr_illegal,
    output logic [CYCLE_OUT_WIDTH-1:0] cycle
);

`ifdef PERF_HPM_EN
    localparam logic [3:0] INH_MASK = 4'b1101;
`else
    localparam logic [3:0] INH_MASK = 4'b0101;
`endif

    logic [CNT_WIDTH-1:0] mcycle, minstret, mhpm3;
    logic [3:0]           inh_q, inh_d;
    logic [31:0]          rdata_q, rd_val;
    logic                 rvalid_q, illegal_q, rd_ill, wr_ill;

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
        .clk_i(clk), .rst_i(rst), .inc_i(1'b1), .inhibit_i(inh_q[INH_CY]),
        .wr_lo_i(csr_we && csr_waddr == CSR_MCYCLE),
        .wr_hi_i(csr_we && csr_waddr == CSR_MCYCLEH),
        .wdata_i(csr_wdata), .value_o(mcycle)
    );

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
        .clk_i(clk), .rst_i(rst), .inc_i(retire_valid), .inhibit_i(inh_q[INH_IR]),
        .wr_lo_i(csr_we && csr_waddr == CSR_MINSTRET),
        .wr_hi_i(csr_we && csr_waddr == CSR_MINSTRETH),
        .wdata_i(csr_wdata), .value_o(minstret)
    );

`ifdef PERF_HPM_EN
    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mhpm3 (
        .clk_i(clk), .rst_i(rst), .inc_i(stall), .inhibit_i(inh_q[INH_HPM3]),
        .wr_lo_i(csr_we && csr_waddr == CSR_MHPMCOUNTER3),
        .wr_hi_i(csr_we && csr_waddr == CSR_MHPMCOUNTER3H),
        .wdata_i(csr_wdata), .value_o(mhpm3)
    );
`else
    // HPM addresses stay legal but read as zero; stall has no consumer.
    logic unused_stall;
    assign unused_stall = stall;
    assign mhpm3        = '0;
`endif

    assign inh_d = (csr_we && csr_waddr == CSR_MCOUNTINHIBIT) ? (csr_wdata[3:0] & INH_MASK)
                                                               : inh_q;

    // Read mux sees the pre-update counter values, so a same-cycle write is not visible.
    always_comb begin
        rd_val = '0;
        rd_ill = 1'b0;
        case (csr_raddr)
            CSR_MCYCLE,       CSR_CYCLE:        rd_val = mcycle[31:0];
            CSR_MCYCLEH,      CSR_CYCLEH:       rd_val = 32'(mcycle[CNT_WIDTH-1:32]);
            CSR_MINSTRET,     CSR_INSTRET:      rd_val = minstret[31:0];
            CSR_MINSTRETH,    CSR_INSTRETH:     rd_val = 32'(minstret[CNT_WIDTH-1:32]);
            CSR_MHPMCOUNTER3, CSR_HPMCOUNTER3:  rd_val = mhpm3[31:0];
            CSR_MHPMCOUNTER3H,CSR_HPMCOUNTER3H: rd_val = 32'(mhpm3[CNT_WIDTH-1:32]);
            CSR_MCOUNTINHIBIT:                  rd_val = {28'b0, inh_q};
            default:                            rd_ill = 1'b1;
        endcase
    end

    always_comb begin
        wr_ill = 1'b1;
        case (csr_waddr)
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
            CSR_MHPMCOUNTER3, CSR_MHPMCOUNTER3H, CSR_MCOUNTINHIBIT: wr_ill = 1'b0;
            default:                                                wr_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inh_q     <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            inh_q     <= inh_d;
            rvalid_q  <= csr_re;
            illegal_q <= (csr_re && rd_ill) || (csr_we && wr_ill);
            if (csr_re) rdata_q <= rd_val;
        end
    end

    assign csr_rdata   = rdata_q;
    assign csr_rvalid  = rvalid_q;
    assign csr_illegal = illegal_q;
    // mcycle is itself a flop, so its low bits are the registered cycle output.
    assign cycle       = mcycle[CYCLE_OUT_WIDTH-1:0];

endmodule

// File: tb/tb_perf_counters.sv
// Directed bench for perf_counters: read expectations are queued when a read
// is issued and popped when csr_rvalid returns one cycle later.
module tb_perf_counters;

    logic        clk = 1'b0;
    logic        rst;
    logic        retire_valid, stall;
    logic        csr_re, csr_we;
    logic [11:0] csr_raddr, csr_waddr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        csr_rvalid, csr_illegal;
    logic [31:0] cycle;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

`ifdef PERF_HPM_EN
    localparam logic [31:0] INH_RD = 32'hD;
    localparam bit          HPM    = 1'b1;
`else
    localparam logic [31:0] INH_RD = 32'h5;
    localparam bit          HPM    = 1'b0;
`endif

    perf_counters #(.CNT_WIDTH(64), .CYCLE_OUT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .stall(stall),
        .csr_re(csr_re), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_rvalid(csr_rvalid), .csr_we(csr_we), .csr_waddr(csr_waddr),
        .csr_wdata(csr_wdata), .csr_illegal(csr_illegal), .cycle(cycle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Starts one time unit after an edge, spends exactly one edge.
    task automatic access(input logic re, input logic [11:0] ra, input logic we,
                          input logic [11:0] wa, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_ill, input string tag);
        csr_re = re; csr_raddr = ra; csr_we = we; csr_waddr = wa; csr_wdata = wd;
        if (re) exp_q.push_back(exp_d);
        @(posedge clk); #1;
        csr_re = 1'b0; csr_we = 1'b0;
        chk({tag, "_rvalid"}, 64'(csr_rvalid), 64'(re));
        if (csr_rvalid) begin
            if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
            else                   chk({tag, "_rdata"}, 64'(csr_rdata), 64'(exp_q.pop_front()));
        end
        chk({tag, "_illegal"}, 64'(csr_illegal), 64'(exp_ill));
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e, input string tag);
        access(1'b1, a, 1'b0, 12'h0, 32'h0, e, 1'b0, tag);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic ill, input string tag);
        access(1'b0, 12'h0, 1'b1, a, d, 32'h0, ill, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] pat;
        rst = 1'b1; retire_valid = 1'b0; stall = 1'b0;
        csr_re = 1'b0; csr_we = 1'b0; csr_raddr = '0; csr_waddr = '0; csr_wdata = '0;
        pat = 12'b1011_0110_1001;

        #10;
        chk("rst_cycle",   64'(cycle), 64'd0);
        chk("rst_rvalid",  64'(csr_rvalid), 64'd0);
        chk("rst_illegal", 64'(csr_illegal), 64'd0);
        chk("rst_rdata",   64'(csr_rdata), 64'd0);
        #10 rst = 1'b0;

        idle(10);
        chk("run10_cycle", 64'(cycle), 64'd10);
        rd(12'hB00, 32'd10, "run10_mcycle");
        rd(12'hB02, 32'd0,  "run10_minstret");

        // Read accepted, then reset before its response is consumed.
        csr_re = 1'b1; csr_raddr = 12'hB00;
        @(posedge clk); #1;
        csr_re = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_cycle",  64'(cycle), 64'd0);
        chk("midrst_rvalid", 64'(csr_rvalid), 64'd0);
        #2 rst = 1'b0;
        idle(1);
        chk("first_edge_cycle", 64'(cycle), 64'd1);

        for (int i = 0; i < 12; i++) begin
            retire_valid = pat[i];
            idle(1);
        end
        retire_valid = 1'b0;
        rd(12'hB02, 32'd7, "ret_minstret");
        rd(12'hC02, 32'd7, "ret_instret");
        rd(12'hB82, 32'd0, "ret_minstreth");

        // Carry from low into high half.
        wr(12'hB00, 32'hFFFF_FFFE, 1'b0, "wr_mcycle");
        wr(12'hB80, 32'h0,         1'b0, "wr_mcycleh");
        idle(3);
        chk("carry_cycle", 64'(cycle), 64'd1);
        rd(12'hB00, 32'd1, "carry_lo");
        rd(12'hB80, 32'd1, "carry_hi");
        access(1'b1, 12'hB00, 1'b1, 12'hB00, 32'hABCD, 32'd3, 1'b0, "rw_same");
        rd(12'hB00, 32'hABCD, "rw_after");

        // Inhibit CY and IR; retires must not count.
        wr(12'h320, 32'h5, 1'b0, "inh_on");
        retire_valid = 1'b1;
        idle(20);
        chk("inh_cycle", 64'(cycle), 64'hABCF);
        rd(12'hB00, 32'hABCF, "inh_mcycle");
        rd(12'hB02, 32'd7,    "inh_minstret");
        wr(12'h320, 32'h0, 1'b0, "inh_off");
        rd(12'hB00, 32'hABCF, "resume_mcycle0");
        retire_valid = 1'b0;
        rd(12'hB00, 32'hABD0, "resume_mcycle1");
        rd(12'hB02, 32'd8,    "resume_minstret");
        wr(12'h320, 32'hFFFF_FFFF, 1'b0, "inh_all");
        rd(12'h320, INH_RD, "inh_readback");

        // Illegal accesses (counters frozen at 0x1_0000ABD3).
        wr(12'hC00, 32'h1234, 1'b1, "wr_ro");
        rd(12'hC00, 32'hABD3, "ro_unchanged");
        rd(12'hC80, 32'd1,    "ro_cycleh");
        idle(1);
        chk("rdata_hold", 64'(csr_rdata), 64'd1);
        chk("idle_rvalid", 64'(csr_rvalid), 64'd0);
        access(1'b1, 12'h7FF, 1'b0, 12'h0, 32'h0, 32'h0, 1'b1, "rd_unmapped");
        wr(12'h123, 32'h5, 1'b1, "wr_unmapped");
        access(1'b1, 12'h7FF, 1'b1, 12'hC80, 32'h9, 32'h0, 1'b1, "both_ill");
        idle(1);
        chk("single_pulse", 64'(csr_illegal), 64'd0);

        // Optional HPM counter: stall cycles.
        wr(12'h320, 32'h5, 1'b0, "hpm_uninh");
        stall = 1'b1;
        idle(4);
        stall = 1'b0;
        rd(12'hB03, HPM ? 32'd4 : 32'd0, "hpm_count");
        wr(12'hB03, 32'h55, 1'b0, "hpm_wr");
        rd(12'hC03, HPM ? 32'h55 : 32'd0, "hpm_shadow");
        rd(12'hC83, 32'd0, "hpm_shadow_hi");

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_counters.md
Name: perf_counters

Overview:
- Machine-mode performance counter unit of the RISC-V core; sits beside the writeback stage.
- Consumes retire strobes from writeback.
- Serves the CSR read/write port of the execute stage.
- Drives the core's top-level `cycle` output that the simulation bench monitors.
- Implements mcycle, minstret, their user read-only shadows, and mcountinhibit.

Parameters:
- CNT_WIDTH, 64, width of each counter (split into low/high 32-bit CSR halves).
- CYCLE_OUT_WIDTH, 32, width of the `cycle` output port (low bits of mcycle).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- retire_valid  in  1  one instruction retired this cycle
- stall  in  1  pipeline stall this cycle (used only with PERF_HPM_EN)
- csr_re  in  1  CSR read request
- csr_raddr  in  12  CSR read address
- csr_rdata  out  32  read data, registered
- csr_rvalid  out  1  read response strobe
- csr_we  in  1  CSR write request
- csr_waddr  in  12  CSR write address
- csr_wdata  in  32  write data
- csr_illegal  out  1  one-cycle pulse: unmapped address, or write to a read-only address
- cycle  out  CYCLE_OUT_WIDTH  low bits of mcycle, registered

Behaviour:
- **Clock and reset:** one clock. Reset is asynchronous and active-high on `rst`. Reset clears every counter, mcountinhibit, csr_rdata, csr_rvalid, csr_illegal and cycle to 0. Asserting `rst` mid-operation clears everything immediately; any in-flight read response is dropped.
- **Address map:**
  - mcycle: 0xB00 / 0xB80
  - minstret: 0xB02 / 0xB82
  - mcountinhibit: 0x320 (bit0 CY, bit2 IR, other bits read 0, writes ignored)
  - read-only shadows cycle: 0xC00 / 0xC80
  - read-only shadows instret: 0xC02 / 0xC82
- **mcycle counting:** +1 every clock while CY=0. The first edge after reset release gives mcycle=1 and cycle=1.
- **minstret counting:** +1 on each clock with retire_valid=1 and IR=0.
- **Wrap:** 2^CNT_WIDTH-1 wraps to 0. Carry from low to high is within the same cycle.
- **Writes:**
  - Writing a half replaces that half only.
  - The written counter does not increment that cycle; write wins over increment.
  - The other half holds its value that cycle.
  - Writing mcountinhibit takes effect from the next cycle.
- **Reads:**
  - A read accepted on edge N returns on csr_rdata with csr_rvalid=1 during cycle N+1 (one-cycle latency).
  - Read data is the pre-update value, i.e. before any same-cycle write or increment.
  - Back-to-back reads are supported every cycle.
  - csr_rdata holds its value when csr_rvalid=0.
- **Illegal accesses:**
  - Read of an unmapped address: csr_rdata=0, csr_rvalid=1, csr_illegal=1, aligned with rvalid.
  - Write to a 0xC** address or an unmapped address: no state change; csr_illegal pulses the cycle after.
  - Read and write illegal in the same cycle produce a single pulse.
- **Simultaneous read and write to the same address:** the read returns the old value.
- **cycle output:** registered copy of mcycle[CYCLE_OUT_WIDTH-1:0], updated the same edge as mcycle.

Optional Feature:
- **Macro:** PERF_HPM_EN.
- **Defined:** adds mhpmcounter3 (0xB03 / 0xB83, shadow 0xC03 / 0xC83), counting cycles with stall=1. It is inhibited by mcountinhibit bit3 and has the same write/wrap/read rules as the other counters.
- **Undefined:** those addresses read 0 and are legal; writes are ignored without illegal; `stall` is ignored; bit3 reads 0.

Decomposition:
- **Shared package perf_pkg:**
  - 12-bit CSR address constants for all addresses above.
  - Inhibit bit indices CY=0, IR=2, HPM3=3.
  - CNT_WIDTH default.
- **Sub-module perf_counter:**
  - One CNT_WIDTH counter with inc, inhibit, wr_lo, wr_hi and wdata inputs and a value output.
  - Instantiated 2× (3× with PERF_HPM_EN).
  - Top level holds only address decode, the read mux/register and mcountinhibit.

Test Plan:
- Reset 20 ns, release, run 10 edges -> cycle=10, mcycle=10, minstret=0; assert rst mid-run -> cycle=0 immediately, before the next edge.
- retire_valid high 7 of 12 cycles -> read 0xB02 returns 7; read 0xC02 returns 7; 0xB82 returns 0.
- Write 0xB00=0xFFFFFFFE, 0xB80=0; after 3 free cycles -> read 0xB80 returns 1 and 0xB00 returns 1 (carry crossed); write and read 0xB00 in the same cycle -> old value returned.
- Write 0x320=0x5 -> mcycle and minstret frozen 20 cycles despite retires; write 0x320=0 -> counting resumes next cycle; read 0x320 after writing 0xFFFFFFFF -> 0x5 (0xD with PERF_HPM_EN).
- Write 0xC00=0x1234 -> no change, csr_illegal pulse next cycle; read 0x7FF -> rdata=0, rvalid=1, illegal=1.
- PERF_HPM_EN: stall high 4 cycles -> read 0xB03 returns 4; without the macro -> returns 0, illegal=0.
